// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/response bundle for the nibble-serial adder: two requesters in, one tagged response out.
interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;

  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_sum;
  logic             resp_cout;
  logic             resp_id;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_sum, resp_cout, resp_id
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_sum, resp_cout, resp_id
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Two-requester arbiter that adds the granted operands one nibble per cycle through
// a single 4-bit ripple-carry slice, then presents the tagged result until taken.
//
// state | meaning
// IDLE  | arbitrating; winner's ready is high, operands latched on transfer
// RUN   | one nibble per cycle, LSB first, carry held in a register
// DONE  | result presented on resp_*; waits for resp_ready

module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic c1, c2, c3;

  assign sum[0] = a[0] ^ b[0] ^ cin;
  assign c1     = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
  assign sum[1] = a[1] ^ b[1] ^ c1;
  assign c2     = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
  assign sum[2] = a[2] ^ b[2] ^ c2;
  assign c3     = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));
  assign sum[3] = a[3] ^ b[3] ^ c3;
  assign cout   = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));
endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  nibble_serial_add_ctrl_if.slave   bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             pointer;
  logic             carry;
  logic             id_q;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_q, b_q, sum_q;

  logic             grant0, grant1, accept, last_nib;
  logic [CW+1:0]    nib_base;
  logic [3:0]       a_nib, b_nib, slice_sum;
  logic             slice_cout;

  // Ready is forced low during reset so no transfer can be seen while rst is high.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (bus.req0_valid && (!bus.req1_valid || !pointer))
        grant0 = 1'b1;
      else if (bus.req1_valid)
        grant1 = 1'b1;
    end
  end

  assign accept         = grant0 | grant1;
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  assign nib_base = {count, 2'b00};
  assign a_nib    = a_q[nib_base +: 4];
  assign b_nib    = b_q[nib_base +: 4];
  assign last_nib = (count == CW'(NIB - 1));

  nibble_add4 u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)         state_nxt = RUN;
      RUN:     if (last_nib)       state_nxt = DONE;
      DONE:    if (bus.resp_ready) state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pointer <= 1'b0;
      carry   <= 1'b0;
      id_q    <= 1'b0;
      count   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= grant1 ? bus.req1_a   : bus.req0_a;
            b_q   <= grant1 ? bus.req1_b   : bus.req0_b;
            carry <= grant1 ? bus.req1_cin : bus.req0_cin;
            id_q  <= grant1;
            count <= '0;
          end
        end
        RUN: begin
          sum_q[nib_base +: 4] <= slice_sum;
          carry                <= slice_cout;
          count                <= last_nib ? '0 : count + CW'(1);
        end
        DONE: begin
          // The requester just served loses priority for the next contested round.
          if (bus.resp_ready) pointer <= ~id_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_valid = (state == DONE);
  assign bus.resp_sum   = sum_q;
  assign bus.resp_cout  = carry;
  assign bus.resp_id    = id_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed and randomized checks of the nibble-serial adder against an arithmetic reference.
module tb_nibble_serial_add_ctrl;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  nibble_serial_add_ctrl_if #(.WIDTH(W)) bus ();

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         id;
    logic [W:0] full;
  } exp_t;

  int         errors = 0;
  int         checks = 0;
  exp_t       q[$];
  exp_t       e;
  int         lat, n, done_ops;
  int         served[2];
  int         other_grants[2];
  bit         pend[2];
  logic [W-1:0] a_r[2], b_r[2];
  logic       cin_r[2];
  logic [W-1:0] hs;
  logic       hc, hi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  task automatic check_resp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input bit id);
    logic [W:0] f;
    f = model(a, b, cin);
    chk({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, "_sum"},   32'(bus.resp_sum),   32'(f[W-1:0]));
    chk({tag, "_cout"},  32'(bus.resp_cout),  32'(f[W]));
    chk({tag, "_id"},    32'(bus.resp_id),    32'(id));
  endtask

  task automatic set_req(input int r, input bit v);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_a = a_r[0]; bus.req0_b = b_r[0]; bus.req0_cin = cin_r[0];
    end else begin
      bus.req1_valid = v; bus.req1_a = a_r[1]; bus.req1_b = b_r[1]; bus.req1_cin = cin_r[1];
    end
  endtask

  // Called just after the negedge that follows an accept edge.
  task automatic wait_resp(input string tag, output int l);
    l = 0;
    while (!bus.resp_valid && l < 50) begin
      @(posedge clk); @(negedge clk); l++;
    end
    if (!bus.resp_valid) chk({tag, "_timeout"}, 32'(bus.resp_valid), 32'd1);
  endtask

  // Issue one op from requester r alone; returns at the negedge where resp_valid is high.
  task automatic run_op(input string tag, input int r, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin, output int l);
    int k;
    @(negedge clk);
    a_r[r] = a; b_r[r] = b; cin_r[r] = cin;
    set_req(r, 1'b1);
    #1;
    k = 0;
    while (!(r == 0 ? bus.req0_ready : bus.req1_ready) && k < 100) begin
      @(negedge clk); #1; k++;
    end
    if (k >= 100) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    a_r[r] = W'($urandom); b_r[r] = W'($urandom);
    set_req(r, 1'b0);
    wait_resp(tag, l);
  endtask

  task automatic take(input string tag);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_taken"}, 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_accept(input int r);
    e.id   = (r != 0);
    e.full = model(a_r[r], b_r[r], cin_r[r]);
    q.push_back(e);
    chk("rand_wait_bound", 32'(other_grants[r] <= 1), 32'd1);
    other_grants[r] = 0;
    pend[r] = 1'b0;
    served[r]++;
    if (pend[1-r]) other_grants[1-r]++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0_valid = 1'b1; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
    bus.resp_ready = 1'b1;
    #2;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_sum",   32'(bus.resp_sum),   32'd0);
    chk("rst_resp_cout",  32'(bus.resp_cout),  32'd0);
    chk("rst_resp_id",    32'(bus.resp_id),    32'd0);
    chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Basic add and latency
    run_op("t1", 0, 16'h1234, 16'h4321, 1'b0, lat);
    chk("t1_latency", 32'(lat), 32'(NIB));
    chk("t1_sum_const", 32'(bus.resp_sum), 32'h5555);
    check_resp("t1", 16'h1234, 16'h4321, 1'b0, 1'b0);
    take("t1");

    // Full carry ripple through every nibble
    run_op("t2a", 1, 16'hFFFF, 16'h0001, 1'b0, lat);
    chk("t2a_sum_const",  32'(bus.resp_sum),  32'h0000);
    chk("t2a_cout_const", 32'(bus.resp_cout), 32'd1);
    check_resp("t2a", 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    take("t2a");
    run_op("t2b", 1, 16'hFFFF, 16'h0000, 1'b1, lat);
    check_resp("t2b", 16'hFFFF, 16'h0000, 1'b1, 1'b1);
    take("t2b");

    // Contention from reset: req0 first, then req1, then req0 again
    do_reset();
    @(negedge clk);
    a_r[0] = 16'h0F0F; b_r[0] = 16'h00F1; cin_r[0] = 1'b0; set_req(0, 1'b1);
    a_r[1] = 16'h8000; b_r[1] = 16'h8000; cin_r[1] = 1'b1; set_req(1, 1'b1);
    bus.resp_ready = 1'b1;
    #1;
    chk("t3_first_r0_ready", 32'(bus.req0_ready), 32'd1);
    chk("t3_first_r1_ready", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    set_req(0, 1'b0);
    wait_resp("t3a", lat);
    check_resp("t3a", 16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!bus.req1_ready && n < 20);
    chk("t3_second_r1_ready", 32'(bus.req1_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    set_req(1, 1'b0);
    wait_resp("t3b", lat);
    check_resp("t3b", 16'h8000, 16'h8000, 1'b1, 1'b1);
    @(posedge clk); @(negedge clk);
    a_r[0] = 16'h7777; b_r[0] = 16'h1111; cin_r[0] = 1'b1; set_req(0, 1'b1);
    a_r[1] = 16'h0101; b_r[1] = 16'h1010; cin_r[1] = 1'b0; set_req(1, 1'b1);
    #1;
    chk("t3_third_r0_ready", 32'(bus.req0_ready), 32'd1);
    chk("t3_third_r1_ready", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    wait_resp("t3c", lat);
    check_resp("t3c", 16'h7777, 16'h1111, 1'b1, 1'b0);
    take("t3c");

    // Back-pressure in DONE
    bus.resp_ready = 1'b0;
    run_op("t4", 0, 16'hABCD, 16'h1357, 1'b0, lat);
    check_resp("t4", 16'hABCD, 16'h1357, 1'b0, 1'b0);
    hs = bus.resp_sum; hc = bus.resp_cout; hi = bus.resp_id;
    a_r[1] = 16'h2222; b_r[1] = 16'h3333; cin_r[1] = 1'b0; set_req(1, 1'b1);
    a_r[0] = 16'h4444; b_r[0] = 16'h5555; cin_r[0] = 1'b0; set_req(0, 1'b1);
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      chk("t4_hold_valid",  32'(bus.resp_valid), 32'd1);
      chk("t4_hold_sum",    32'(bus.resp_sum),   32'(hs));
      chk("t4_hold_cout",   32'(bus.resp_cout),  32'(hc));
      chk("t4_hold_id",     32'(bus.resp_id),    32'(hi));
      chk("t4_hold_r0_rdy", 32'(bus.req0_ready), 32'd0);
      chk("t4_hold_r1_rdy", 32'(bus.req1_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    chk("t4_taken", 32'(bus.resp_valid), 32'd0);

    // Reset in the second RUN cycle
    @(negedge clk);
    a_r[1] = 16'h1111; b_r[1] = 16'h2222; cin_r[1] = 1'b1; set_req(1, 1'b1);
    @(posedge clk); @(negedge clk);
    set_req(1, 1'b0);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    set_req(0, 1'b1);
    #1;
    chk("t5_rst_valid",  32'(bus.resp_valid), 32'd0);
    chk("t5_rst_sum",    32'(bus.resp_sum),   32'd0);
    chk("t5_rst_cout",   32'(bus.resp_cout),  32'd0);
    chk("t5_rst_id",     32'(bus.resp_id),    32'd0);
    chk("t5_rst_r0_rdy", 32'(bus.req0_ready), 32'd0);
    chk("t5_rst_r1_rdy", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 1'b0);
    repeat (NIB + 2) @(negedge clk);
    chk("t5_no_stale_resp", 32'(bus.resp_valid), 32'd0);
    run_op("t5", 0, 16'h00F0, 16'h0F10, 1'b0, lat);
    chk("t5_sum_const", 32'(bus.resp_sum), 32'h1000);
    check_resp("t5", 16'h00F0, 16'h0F10, 1'b0, 1'b0);
    take("t5");

    // Randomized traffic from both requesters
    done_ops = 0;
    served[0] = 0; served[1] = 0;
    other_grants[0] = 0; other_grants[1] = 0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int cyc = 0; cyc < 40000 && done_ops < 600; cyc++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (!pend[r]) begin
          a_r[r] = W'($urandom); b_r[r] = W'($urandom); cin_r[r] = 1'($urandom);
          if ($urandom_range(0, 2) != 0) begin
            pend[r] = 1'b1;
            other_grants[r] = 0;
            set_req(r, 1'b1);
          end else begin
            set_req(r, 1'b0);
          end
        end
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rand_ready_onehot", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
      if (bus.resp_valid && bus.resp_ready) begin
        if (q.size() == 0) begin
          chk("rand_unexpected_resp", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          chk("rand_sum",  32'(bus.resp_sum),  32'(e.full[W-1:0]));
          chk("rand_cout", 32'(bus.resp_cout), 32'(e.full[W]));
          chk("rand_id",   32'(bus.resp_id),   32'(e.id));
        end
        done_ops++;
      end
      if (bus.req0_valid && bus.req0_ready) rand_accept(0);
      if (bus.req1_valid && bus.req1_ready) rand_accept(1);
    end
    @(negedge clk);
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    bus.resp_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      #1;
      if (bus.resp_valid) begin
        e = q.pop_front();
        chk("drain_sum",  32'(bus.resp_sum),  32'(e.full[W-1:0]));
        chk("drain_cout", 32'(bus.resp_cout), 32'(e.full[W]));
        chk("drain_id",   32'(bus.resp_id),   32'(e.id));
        done_ops++;
      end
      @(negedge clk);
      n++;
    end
    chk("rand_queue_empty", 32'(q.size()), 32'd0);
    chk("rand_ops_done",    32'(done_ops >= 600), 32'd1);
    chk("rand_served_r0",   32'(served[0] >= 100), 32'd1);
    chk("rand_served_r1",   32'(served[1] >= 100), 32'd1);
    repeat (2) @(negedge clk);
    chk("rand_no_extra_resp", 32'(bus.resp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Two-requester arbiter and sequencer built around one instance of the team's 4-bit ripple-carry adder slice. Each request supplies WIDTH-bit operands and a carry-in. The block grants one request at a time and adds it one nibble per cycle, LSB nibble first, carrying between nibbles through a registered carry. It returns the full sum and carry-out on a valid/ready response port tagged with the requester ID.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and ≥ 8
NIB, WIDTH/4, derived nibble count; not overridable

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  WIDTH  requester 0 operand a
req0_b  input  WIDTH  requester 0 operand b
req0_cin  input  1  requester 0 carry-in
req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as requester 0, for requester 1
resp_valid  output  1  result available
resp_ready  input  1  consumer takes result
resp_sum  output  WIDTH  sum of a+b+cin, modulo 2^WIDTH
resp_cout  output  1  carry-out of the top nibble
resp_id  output  1  requester that issued this result

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset: state=IDLE, pointer=0, count=0, carry=0, operand/sum registers=0. Outputs: resp_valid=0, resp_sum=0, resp_cout=0, resp_id=0. req0_ready=req1_ready=0 while rst is high.
- Reset mid-operation aborts the operation. No response is produced; the in-flight request is lost.
- FSM has three states: IDLE, RUN, DONE.
- IDLE arbitration (combinational ready):
  - Only one valid: that requester wins.
  - Both valid: the requester equal to pointer wins.
  - Winner's ready=1; loser's ready=0. Ready is 0 in RUN and DONE.
- Handshake: a transfer occurs on a clock edge with valid&&ready. The block latches a, b, cin into carry, sets id, sets count=0, and moves to RUN.
- RUN, each cycle:
  - Slice inputs: a[4*count+3:4*count], b[same], carry.
  - The slice sum is written into the matching nibble of the sum register; carry takes the slice carry-out; count increments.
  - When count==NIB-1 at the edge, go to DONE. count wraps to 0.
- DONE: resp_valid=1. resp_sum and resp_cout (= carry) and resp_id are held stable.
  - On resp_valid&&resp_ready: resp_valid drops next cycle, state returns to IDLE, pointer becomes ~resp_id.
- Latency: resp_valid rises NIB cycles after the accept edge.
- Minimum issue interval is NIB+2 cycles: RUN×NIB, DONE, IDLE. No new acceptance is allowed before the response is taken.
- A requester holding valid while not granted must keep its operands stable. The block samples only at acceptance.
- Operand changes after acceptance do not affect the in-flight result.
- resp_ready held low: DONE holds indefinitely; there is no timeout.

Test Plan:
1. WIDTH=16. req0 a=0x1234, b=0x4321, cin=0 → resp_sum=0x5555, resp_cout=0, resp_id=0. resp_valid rises exactly 4 cycles after the accept edge.
2. req1 a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, id=1. This checks carry propagation through all 4 nibbles. Then a=0xFFFF, b=0x0000, cin=1 → 0x0000, cout=1.
3. Both requests valid from reset → req0 is served first; req1 is served next without deasserting. Then both again → req0 is served, because pointer=0 after req1.
4. resp_ready held low for 6 cycles in DONE → resp_valid, sum, cout, id stay stable. Both readys stay 0 throughout; the response is taken on the cycle resp_ready rises.
5. Assert rst during the second RUN cycle → all outputs are 0 immediately. After release, IDLE accepts a new request, and a=0x00F0, b=0x0F10 → 0x1000, cout=0.
6. Random back-to-back ops from both requesters (≥500) → every result equals a+b+cin against a reference model. No request is lost or duplicated, and no requester is starved.
